// File: rtl/stage_memory_pkg.sv
// Shared constants for the memory stage: access widths, FSM state encoding
// and the alignment rule used by both the stage and its lane steering.
package stage_memory_pkg;

    localparam logic [1:0] WIDTH_BYTE = 2'd0;
    localparam logic [1:0] WIDTH_HALF = 2'd1;
    localparam logic [1:0] WIDTH_WORD = 2'd2;

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_BUSY = 1'b1;

    // Halfwords must be even, words must sit on a 4-byte boundary.
    function automatic logic misaligned(input logic [1:0] width, input logic [1:0] offset);
        return ((width == WIDTH_HALF) && offset[0]) ||
               ((width == WIDTH_WORD) && (offset != 2'b00));
    endfunction

endpackage

// File: rtl/stage_memory_align.sv
// Byte-lane steering for the memory stage: store byte enables and lane
// replication, plus load lane extraction with sign/zero extension.
module mem_align
    import stage_memory_pkg::*;
(
    input  logic [1:0]  width,
    input  logic [1:0]  offset,
    input  logic [31:0] st_data,
    output logic [3:0]  st_be,
    output logic [31:0] st_wdata,
    input  logic [31:0] ld_rdata,
    input  logic        ld_extend,
    output logic [31:0] ld_data
);

    logic [31:0] ld_shifted;

    // Store side: enable the addressed lanes and replicate data across the word.
    always_comb begin
        st_be    = 4'hF;
        st_wdata = st_data;
        case (width)
            WIDTH_BYTE: begin
                st_be    = 4'b0001 << offset;
                st_wdata = {4{st_data[7:0]}};
            end
            WIDTH_HALF: begin
                st_be    = 4'b0011 << offset;
                st_wdata = {2{st_data[15:0]}};
            end
            default: ;
        endcase
    end

    // Load side: bring the addressed lane down to bit 0, then extend.
    always_comb begin
        ld_shifted = ld_rdata >> {offset, 3'b000};
        case (width)
            WIDTH_BYTE: ld_data = {{24{ld_extend & ld_shifted[7]}}, ld_shifted[7:0]};
            WIDTH_HALF: ld_data = {{16{ld_extend & ld_shifted[15]}}, ld_shifted[15:0]};
            default:    ld_data = ld_rdata;
        endcase
    end

endmodule

// File: rtl/stage_memory.sv
// Memory stage of the 5-stage pipeline: load/store over a req/ack bus,
// branch/jump resolution into a fetch redirect, and the writeback register.
module stage_memory
    import stage_memory_pkg::*;
#(
    parameter int FAULT_MISALIGN = 1
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        mem_valid,
    input  logic [31:0] mem_pc,
    input  logic [31:0] mem_data0,
    input  logic [31:0] mem_data1,
    input  logic        mem_read_r,
    input  logic        mem_write_r,
    input  logic        mem_extend_r,
    input  logic [1:0]  mem_width_r,
    input  logic        mem_jmp_r,
    input  logic        mem_br_r,
    input  logic        mem_br_inv_r,
    input  logic [4:0]  wb_reg_r,
    output logic        mem_stall,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [29:0] dmem_addr,
    output logic [3:0]  dmem_be,
    output logic [31:0] dmem_wdata,
    input  logic        dmem_ack,
    input  logic [31:0] dmem_rdata,
    output logic        fe_redirect,
    output logic [31:0] fe_target,
    output logic        mem_fault,
    output logic        wb_valid,
    output logic [31:0] wb_pc,
    output logic [4:0]  wb_reg,
    output logic [31:0] wb_data
);

    logic [0:0]  state;
    logic        memop;
    logic        misalign;
    logic        fault;
    logic        done;
    logic        writes_back;
    logic [1:0]  raw_off;
    logic [1:0]  eff_off;
    logic [3:0]  be_c;
    logic [31:0] wdata_c;
    logic [31:0] load_c;

    mem_align u_align (
        .width     (mem_width_r),
        .offset    (eff_off),
        .st_data   (mem_data1),
        .st_be     (be_c),
        .st_wdata  (wdata_c),
        .ld_rdata  (dmem_rdata),
        .ld_extend (mem_extend_r),
        .ld_data   (load_c)
    );

    // Classify the current instruction and derive stall/redirect.
    // With faulting disabled the low address bits are dropped so the lane
    // logic always sees an aligned offset.
    always_comb begin
        raw_off = mem_data0[1:0];
        case (mem_width_r)
            WIDTH_WORD: eff_off = 2'b00;
            WIDTH_HALF: eff_off = {raw_off[1], 1'b0};
            default:    eff_off = raw_off;
        endcase
        memop       = mem_valid & (mem_read_r | mem_write_r);
        misalign    = (FAULT_MISALIGN != 0) ? misaligned(mem_width_r, raw_off) : 1'b0;
        fault       = memop & misalign;
        done        = (state == ST_BUSY) & dmem_ack;
        mem_stall   = memop & ~done & ~misalign;
        writes_back = mem_read_r | ~(mem_write_r | mem_br_r);
        fe_redirect = mem_valid & ~mem_stall &
                      (mem_jmp_r | (mem_br_r & (mem_data0[0] ^ mem_br_inv_r)));
        fe_target   = mem_data1;
    end

    // Bus FSM: launch a registered request from IDLE, hold it until ack.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state      <= ST_IDLE;
            dmem_req   <= 1'b0;
            dmem_we    <= 1'b0;
            dmem_addr  <= '0;
            dmem_be    <= '0;
            dmem_wdata <= '0;
        end else if (state == ST_IDLE) begin
            if (memop && !misalign) begin
                state      <= ST_BUSY;
                dmem_req   <= 1'b1;
                dmem_we    <= mem_write_r;
                dmem_addr  <= mem_data0[31:2];
                dmem_be    <= be_c;
                dmem_wdata <= wdata_c;
            end
        end else begin
            if (dmem_ack) begin
                state    <= ST_IDLE;
                dmem_req <= 1'b0;
            end
        end
    end

    // Writeback bundle and fault pulse; payload only advances on non-stalled cycles.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            wb_valid  <= 1'b0;
            wb_pc     <= '0;
            wb_reg    <= '0;
            wb_data   <= '0;
            mem_fault <= 1'b0;
        end else begin
            wb_valid  <= mem_valid & ~mem_stall & ~fault;
            mem_fault <= fault;
            if (!mem_stall) begin
                wb_pc   <= mem_pc;
                wb_reg  <= (writes_back && !fault) ? wb_reg_r : '0;
                wb_data <= mem_read_r ? load_c : mem_data0;
            end
        end
    end

endmodule

// File: tb/tb_stage_memory.sv
// Randomized self-checking bench for stage_memory with a byte-addressed
// memory model and a per-instruction expectation model.
module tb_stage_memory;

    localparam int K_ALU = 0;
    localparam int K_LD  = 1;
    localparam int K_ST  = 2;
    localparam int K_BR  = 3;
    localparam int K_JMP = 4;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        mem_valid = 1'b0;
    logic [31:0] mem_pc = '0;
    logic [31:0] mem_data0 = '0;
    logic [31:0] mem_data1 = '0;
    logic        mem_read_r = 1'b0;
    logic        mem_write_r = 1'b0;
    logic        mem_extend_r = 1'b0;
    logic [1:0]  mem_width_r = '0;
    logic        mem_jmp_r = 1'b0;
    logic        mem_br_r = 1'b0;
    logic        mem_br_inv_r = 1'b0;
    logic [4:0]  wb_reg_r = '0;
    logic        mem_stall;
    logic        dmem_req;
    logic        dmem_we;
    logic [29:0] dmem_addr;
    logic [3:0]  dmem_be;
    logic [31:0] dmem_wdata;
    logic        dmem_ack = 1'b0;
    logic [31:0] dmem_rdata = '0;
    logic        fe_redirect;
    logic [31:0] fe_target;
    logic        mem_fault;
    logic        wb_valid;
    logic [31:0] wb_pc;
    logic [4:0]  wb_reg;
    logic [31:0] wb_data;

    logic [7:0] bmem [0:63];   // bytes at 0x100..0x13F
    int n_checks = 0;
    int n_pass   = 0;

    stage_memory #(.FAULT_MISALIGN(1)) dut (
        .clk(clk), .reset_n(reset_n), .mem_valid(mem_valid), .mem_pc(mem_pc),
        .mem_data0(mem_data0), .mem_data1(mem_data1), .mem_read_r(mem_read_r),
        .mem_write_r(mem_write_r), .mem_extend_r(mem_extend_r), .mem_width_r(mem_width_r),
        .mem_jmp_r(mem_jmp_r), .mem_br_r(mem_br_r), .mem_br_inv_r(mem_br_inv_r),
        .wb_reg_r(wb_reg_r), .mem_stall(mem_stall), .dmem_req(dmem_req), .dmem_we(dmem_we),
        .dmem_addr(dmem_addr), .dmem_be(dmem_be), .dmem_wdata(dmem_wdata),
        .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata), .fe_redirect(fe_redirect),
        .fe_target(fe_target), .mem_fault(mem_fault), .wb_valid(wb_valid), .wb_pc(wb_pc),
        .wb_reg(wb_reg), .wb_data(wb_data)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
    endtask

    // Called at a negedge; returns at the negedge after the instruction retires,
    // so consecutive calls present instructions back to back.
    task automatic issue(input int kind, input logic [31:0] pc, input logic [31:0] d0,
                         input logic [31:0] d1, input logic [1:0] width, input logic ext,
                         input logic inv, input logic [4:0] rd, input int delay);
        logic        is_mem, mis, redir, wr;
        int          n, off, base;
        logic [3:0]  exp_be;
        logic [31:0] exp_wd, exp_val, word;
        mem_valid    = 1'b1;
        mem_pc       = pc;
        mem_data0    = d0;
        mem_data1    = d1;
        mem_read_r   = (kind == K_LD);
        mem_write_r  = (kind == K_ST);
        mem_extend_r = ext;
        mem_width_r  = width;
        mem_jmp_r    = (kind == K_JMP);
        mem_br_r     = (kind == K_BR);
        mem_br_inv_r = inv;
        wb_reg_r     = rd;
        dmem_ack     = 1'b0;

        is_mem = (kind == K_LD) || (kind == K_ST);
        n      = (width == 2'd0) ? 1 : (width == 2'd1) ? 2 : 4;
        off    = int'(d0[1:0]);
        mis    = is_mem && ((off % n) != 0);
        redir  = (kind == K_JMP) || ((kind == K_BR) && (d0[0] ^ inv));
        wr     = (kind == K_ALU) || (kind == K_LD) || (kind == K_JMP);

        #1;
        check("stall_first", 32'(mem_stall), 32'(is_mem && !mis));
        check("redirect", 32'(fe_redirect), 32'(redir));
        if (redir) check("target", fe_target, d1);

        if (!is_mem || mis) begin
            @(negedge clk);
            check("fault", 32'(mem_fault), 32'(mis));
            check("req_idle", 32'(dmem_req), 32'd0);
            if (mis) check("wb_valid_fault", 32'(wb_valid), 32'd0);
            else begin
                if (wr) check("wb_valid", 32'(wb_valid), 32'd1);
                check("wb_pc", wb_pc, pc);
                check("wb_reg", 32'(wb_reg), wr ? 32'(rd) : 32'd0);
                if (wr) check("wb_data", wb_data, d0);
            end
        end else begin
            exp_be = '0;
            for (int i = 0; i < n; i++) exp_be[off + i] = 1'b1;
            exp_wd = (n == 1) ? {4{d1[7:0]}} : (n == 2) ? {2{d1[15:0]}} : d1;
            base   = int'(d0 - 32'h100) & ~3;
            word   = {bmem[base + 3], bmem[base + 2], bmem[base + 1], bmem[base]};
            exp_val = '0;
            for (int i = 0; i < n; i++)
                exp_val = exp_val | (32'(bmem[base + off + i]) << (8 * i));
            if (ext && n < 4 && exp_val[8 * n - 1])
                exp_val = exp_val | (32'hFFFF_FFFF << (8 * n));

            @(negedge clk);
            for (int k = 0; k <= delay; k++) begin
                check("req_busy", 32'(dmem_req), 32'd1);
                check("addr", {2'b00, dmem_addr}, {2'b00, d0[31:2]});
                check("be", 32'(dmem_be), 32'(exp_be));
                check("we", 32'(dmem_we), 32'(kind == K_ST));
                if (kind == K_ST) check("wdata", dmem_wdata, exp_wd);
                check("wb_valid_busy", 32'(wb_valid), 32'd0);
                if (k == delay) begin
                    dmem_ack   = 1'b1;
                    dmem_rdata = (kind == K_LD) ? word : $urandom;
                end
                #1;
                check("stall_busy", 32'(mem_stall), 32'(k != delay));
                @(negedge clk);
                dmem_ack = 1'b0;
            end
            check("req_done", 32'(dmem_req), 32'd0);
            check("fault_none", 32'(mem_fault), 32'd0);
            if (wr) check("wb_valid_mem", 32'(wb_valid), 32'd1);
            check("wb_pc_mem", wb_pc, pc);
            check("wb_reg_mem", 32'(wb_reg), wr ? 32'(rd) : 32'd0);
            if (kind == K_LD) check("load_data", wb_data, exp_val);
            if (kind == K_ST)
                for (int i = 0; i < n; i++) bmem[base + off + i] = 8'(d1 >> (8 * i));
        end
        mem_valid   = 1'b0;
        mem_read_r  = 1'b0;
        mem_write_r = 1'b0;
        mem_jmp_r   = 1'b0;
        mem_br_r    = 1'b0;
    endtask

    initial begin
        int kind, delay;
        logic [31:0] pc, d0, d1;
        for (int i = 0; i < 64; i++) bmem[i] = 8'($urandom);

        repeat (3) @(negedge clk);
        check("rst_req", 32'(dmem_req), 32'd0);
        check("rst_wb_valid", 32'(wb_valid), 32'd0);
        check("rst_fault", 32'(mem_fault), 32'd0);
        check("rst_wb_reg", 32'(wb_reg), 32'd0);
        check("rst_wb_data", wb_data, 32'd0);
        check("rst_wb_pc", wb_pc, 32'd0);
        reset_n = 1'b1;
        @(negedge clk);

        // Directed scenarios
        issue(K_ST, 32'h10, 32'h100, 32'hDEAD_BEEF, 2'd2, 1'b0, 1'b0, 5'd3, 2);
        bmem[3] = 8'h80;
        issue(K_LD, 32'h14, 32'h103, 32'h0, 2'd0, 1'b1, 1'b0, 5'd4, 0);
        issue(K_LD, 32'h18, 32'h103, 32'h0, 2'd0, 1'b0, 1'b0, 5'd5, 0);
        issue(K_ST, 32'h1C, 32'h102, 32'h0000_1234, 2'd1, 1'b0, 1'b0, 5'd0, 1);
        issue(K_LD, 32'h20, 32'h101, 32'h0, 2'd1, 1'b1, 1'b0, 5'd6, 0);
        issue(K_BR, 32'h24, 32'h1, 32'h0000_0200, 2'd0, 1'b0, 1'b0, 5'd0, 0);
        issue(K_BR, 32'h28, 32'h1, 32'h0000_0300, 2'd0, 1'b0, 1'b1, 5'd0, 0);
        issue(K_JMP, 32'h40, 32'h44, 32'h0000_0500, 2'd0, 1'b0, 1'b0, 5'd1, 0);
        for (int i = 0; i < 4; i++)
            issue(K_LD, 32'h50 + 32'(4 * i), 32'h110 + 32'(4 * i), 32'h0, 2'd2, 1'b0, 1'b0,
                  5'(7 + i), 0);

        // Reset while BUSY, then a late ack that must be ignored
        mem_valid = 1'b1; mem_read_r = 1'b1; mem_width_r = 2'd2; mem_data0 = 32'h120;
        @(negedge clk);
        check("busy_before_rst", 32'(dmem_req), 32'd1);
        reset_n = 1'b0;
        @(negedge clk);
        check("rst_busy_req", 32'(dmem_req), 32'd0);
        check("rst_busy_wb", 32'(wb_valid), 32'd0);
        reset_n = 1'b1; mem_valid = 1'b0; mem_read_r = 1'b0; dmem_ack = 1'b1;
        #1;
        check("late_ack_stall", 32'(mem_stall), 32'd0);
        @(negedge clk);
        dmem_ack = 1'b0;
        check("late_ack_req", 32'(dmem_req), 32'd0);
        check("late_ack_wb", 32'(wb_valid), 32'd0);

        // Randomized traffic
        for (int t = 0; t < 300; t++) begin
            kind  = int'($urandom_range(0, 4));
            delay = int'($urandom_range(0, 3));
            pc    = {$urandom, 2'b00} & 32'h0000_FFFC;
            d1    = $urandom;
            d0    = (kind == K_LD || kind == K_ST) ? 32'h100 + $urandom_range(0, 63) :
                    (kind == K_JMP) ? pc + 32'd4 : $urandom;
            issue(kind, pc, d0, d1, 2'($urandom_range(0, 2)), 1'($urandom),
                  1'($urandom), 5'($urandom), delay);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
